// File: rtl/fft_mul_arbiter.sv
// fft_mul_arbiter
//
// Frame-granular round-robin arbiter that shares one frequency-domain complex
// multiplier between two AXI-Stream requesters. Whole tlast-delimited frames
// are granted one at a time. The owner of every granted frame is pushed into
// a small tag FIFO. The multiplier's in-order result stream is then steered
// back to the owner at the FIFO head, and the tag is popped on that frame's
// tlast.
//
// Optional feature macro: FRAME_CHECK_EN
//   defined   : per-frame beat counter, sticky frame_err, tlast forced on beat
//               FRAME_BEATS when the upstream frame runs long.
//   undefined : frame_err tied 0, tlast forwarded unmodified.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s0_axis_*, s1_axis_*  requester input streams (valid/ready/data/last)
//   mul_in_*              stream towards the multiplier
//   mul_out_*             result stream from the multiplier
//   m0_axis_*, m1_axis_*  per-requester result streams
//   dbg_grant             {busy, owner}
//   dbg_inflight          tag FIFO occupancy
//   frame_err             sticky frame-length error
module fft_mul_arbiter #(
    parameter int DATA_W      = 64,
    parameter int TAG_DEPTH   = 4,
    parameter int FRAME_BEATS = 16384
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         s0_axis_tvalid,
    output logic                         s0_axis_tready,
    input  logic [DATA_W-1:0]            s0_axis_tdata,
    input  logic                         s0_axis_tlast,
    input  logic                         s1_axis_tvalid,
    output logic                         s1_axis_tready,
    input  logic [DATA_W-1:0]            s1_axis_tdata,
    input  logic                         s1_axis_tlast,
    output logic                         mul_in_tvalid,
    input  logic                         mul_in_tready,
    output logic [DATA_W-1:0]            mul_in_tdata,
    output logic                         mul_in_tlast,
    input  logic                         mul_out_tvalid,
    output logic                         mul_out_tready,
    input  logic [DATA_W-1:0]            mul_out_tdata,
    input  logic                         mul_out_tlast,
    output logic                         m0_axis_tvalid,
    input  logic                         m0_axis_tready,
    output logic [DATA_W-1:0]            m0_axis_tdata,
    output logic                         m0_axis_tlast,
    output logic                         m1_axis_tvalid,
    input  logic                         m1_axis_tready,
    output logic [DATA_W-1:0]            m1_axis_tdata,
    output logic                         m1_axis_tlast,
    output logic [1:0]                   dbg_grant,
    output logic [$clog2(TAG_DEPTH):0]   dbg_inflight,
    output logic                         frame_err
);

    localparam int AW = $clog2(TAG_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY0 = 2'd1;
    localparam logic [1:0] ST_BUSY1 = 2'd2;

    // Reject configurations the tag FIFO pointers cannot represent.
    if ((TAG_DEPTH < 2) || ((TAG_DEPTH & (TAG_DEPTH - 1)) != 0) || (FRAME_BEATS < 1)) begin : g_param_check
        $error("fft_mul_arbiter: TAG_DEPTH must be a power of 2 >= 2 and FRAME_BEATS >= 1");
    end

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          rr_r;
    logic          tag_mem_r [TAG_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic          grant_sel_s;
    logic          head_s;
    logic          src_last_s;
    logic          force_last_s;
    logic          fwd_hs_s;
    logic          frame_end_s;

    assign fifo_full_s  = (count_r == (AW+1)'(TAG_DEPTH));
    assign fifo_empty_s = (count_r == {(AW+1){1'b0}});
    assign head_s       = tag_mem_r[rd_ptr_r];

    // Grant decision in IDLE: the sole valid requester wins, rr breaks ties.
    always_comb begin
        push_s      = 1'b0;
        grant_sel_s = 1'b0;
        if ((state_r == ST_IDLE) && !fifo_full_s) begin
            if (s0_axis_tvalid && s1_axis_tvalid) begin
                push_s      = 1'b1;
                grant_sel_s = rr_r;
            end else if (s0_axis_tvalid) begin
                push_s      = 1'b1;
                grant_sel_s = 1'b0;
            end else if (s1_axis_tvalid) begin
                push_s      = 1'b1;
                grant_sel_s = 1'b1;
            end else begin
                push_s      = 1'b0;
                grant_sel_s = 1'b0;
            end
        end else begin
            push_s      = 1'b0;
            grant_sel_s = 1'b0;
        end
    end

    // Forward mux: the granted requester is wired straight to the multiplier.
    always_comb begin
        mul_in_tvalid  = 1'b0;
        mul_in_tdata   = {DATA_W{1'b0}};
        src_last_s     = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state_r)
            ST_BUSY0: begin
                mul_in_tvalid  = s0_axis_tvalid;
                mul_in_tdata   = s0_axis_tdata;
                src_last_s     = s0_axis_tlast;
                s0_axis_tready = mul_in_tready;
            end
            ST_BUSY1: begin
                mul_in_tvalid  = s1_axis_tvalid;
                mul_in_tdata   = s1_axis_tdata;
                src_last_s     = s1_axis_tlast;
                s1_axis_tready = mul_in_tready;
            end
            default: begin
                mul_in_tvalid  = 1'b0;
            end
        endcase
    end

    assign mul_in_tlast = src_last_s | force_last_s;
    assign fwd_hs_s     = mul_in_tvalid & mul_in_tready;
    assign frame_end_s  = fwd_hs_s & mul_in_tlast;

    // Next-state logic: hold the grant until the forwarded frame's last beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (push_s) begin
                    state_nxt_s = grant_sel_s ? ST_BUSY1 : ST_BUSY0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (frame_end_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and round-robin pointer; the loser of a grant is preferred next.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= ST_IDLE;
            rr_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (push_s) begin
                rr_r <= ~grant_sel_s;
            end
        end
    end

    // Return-path steering by the oldest outstanding tag.
    always_comb begin
        m0_axis_tvalid = 1'b0;
        m1_axis_tvalid = 1'b0;
        mul_out_tready = 1'b0;
        if (!fifo_empty_s) begin
            if (head_s) begin
                m1_axis_tvalid = mul_out_tvalid;
                mul_out_tready = m1_axis_tready;
            end else begin
                m0_axis_tvalid = mul_out_tvalid;
                mul_out_tready = m0_axis_tready;
            end
        end else begin
            mul_out_tready = 1'b0;
        end
    end

    assign m0_axis_tdata = mul_out_tdata;
    assign m1_axis_tdata = mul_out_tdata;
    assign m0_axis_tlast = mul_out_tlast;
    assign m1_axis_tlast = mul_out_tlast;

    assign pop_s = (!fifo_empty_s) & mul_out_tvalid & mul_out_tready & mul_out_tlast;

    // Tag storage; contents are don't-care until written, so no reset.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            tag_mem_r[wr_ptr_r] <= grant_sel_s;
        end
    end

    // Tag FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dbg_grant    = {(state_r != ST_IDLE), (state_r == ST_BUSY1)};
    assign dbg_inflight = count_r;

`ifdef FRAME_CHECK_EN
    localparam int CNT_W = $clog2(FRAME_BEATS + 1);

    logic [CNT_W-1:0] beat_cnt_r;
    logic             frame_err_r;

    // The counter holds beats already accepted, so this is the final allowed beat.
    assign force_last_s = (state_r != ST_IDLE) && (beat_cnt_r == CNT_W'(FRAME_BEATS - 1));
    assign frame_err    = frame_err_r;

    // Beat counter per grant and sticky length error (tlast early or missing).
    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_cnt_r  <= {CNT_W{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            if (frame_end_s) begin
                beat_cnt_r <= {CNT_W{1'b0}};
            end else if (fwd_hs_s) begin
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
            if (fwd_hs_s && (src_last_s != force_last_s)) begin
                frame_err_r <= 1'b1;
            end
        end
    end
`else
    assign force_last_s = 1'b0;
    assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fft_mul_arbiter.sv
// Self-checking bench for fft_mul_arbiter (TAG_DEPTH=2, FRAME_BEATS=16).
// Requesters, multiplier (fixed 3-cycle latency queue) and sinks are modelled
// per cycle; inputs are driven at the falling edge and everything is sampled
// 1 ns before the rising edge. Expected results come from per-requester
// scoreboards of what each source had accepted.
module tb_fft_mul_arbiter;
    localparam int DW = 64;
    localparam int TD = 2;
    localparam int FB = 16;
    localparam logic [63:0] XMASK = 64'h5A5A_0F0F_A5A5_F0F0;

    typedef struct packed { logic [63:0] d; logic l; } beat_t;
    typedef struct packed { beat_t b; int t; } mbeat_t;
    typedef struct { bit v0; bit v1; bit owner; } gvec_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic s0_axis_tvalid = 1'b0, s0_axis_tready, s0_axis_tlast = 1'b0;
    logic s1_axis_tvalid = 1'b0, s1_axis_tready, s1_axis_tlast = 1'b0;
    logic [DW-1:0] s0_axis_tdata = '0, s1_axis_tdata = '0;
    logic mul_in_tvalid, mul_in_tready = 1'b0, mul_in_tlast;
    logic [DW-1:0] mul_in_tdata;
    logic mul_out_tvalid = 1'b0, mul_out_tready, mul_out_tlast = 1'b0;
    logic [DW-1:0] mul_out_tdata = '0;
    logic m0_axis_tvalid, m0_axis_tready = 1'b0, m0_axis_tlast;
    logic m1_axis_tvalid, m1_axis_tready = 1'b0, m1_axis_tlast;
    logic [DW-1:0] m0_axis_tdata, m1_axis_tdata;
    logic [1:0] dbg_grant;
    logic [$clog2(TD):0] dbg_inflight;
    logic frame_err;

    always #5 aclk = ~aclk;

    fft_mul_arbiter #(.DATA_W(DW), .TAG_DEPTH(TD), .FRAME_BEATS(FB)) dut (
        .aclk(aclk), .areset(areset),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tlast(s0_axis_tlast),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tlast(s1_axis_tlast),
        .mul_in_tvalid(mul_in_tvalid), .mul_in_tready(mul_in_tready),
        .mul_in_tdata(mul_in_tdata), .mul_in_tlast(mul_in_tlast),
        .mul_out_tvalid(mul_out_tvalid), .mul_out_tready(mul_out_tready),
        .mul_out_tdata(mul_out_tdata), .mul_out_tlast(mul_out_tlast),
        .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tready(m0_axis_tready),
        .m0_axis_tdata(m0_axis_tdata), .m0_axis_tlast(m0_axis_tlast),
        .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tready(m1_axis_tready),
        .m1_axis_tdata(m1_axis_tdata), .m1_axis_tlast(m1_axis_tlast),
        .dbg_grant(dbg_grant), .dbg_inflight(dbg_inflight), .frame_err(frame_err)
    );

    // scoreboards and stimulus state
    beat_t  src_q0[$], src_q1[$], exp0[$], exp1[$];
    mbeat_t mq[$];
    bit     order_q[$], outlog[$];
    bit     mid_frame, m1_seen, m0_last_seen, rst_req, mul_stall, m0_hold;
    int     cyc, n_chk, n_pass, sent0, sent1, got0, got1, fc_cnt;
    int     s_pct = 100, in_pct = 100, out_pct = 100, stub_pct = 100;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive();
        areset = rst_req;
        s0_axis_tvalid = (src_q0.size() > 0) && ($urandom_range(99) < s_pct);
        s0_axis_tdata  = (src_q0.size() > 0) ? src_q0[0].d : '0;
        s0_axis_tlast  = (src_q0.size() > 0) ? src_q0[0].l : 1'b0;
        s1_axis_tvalid = (src_q1.size() > 0) && ($urandom_range(99) < s_pct);
        s1_axis_tdata  = (src_q1.size() > 0) ? src_q1[0].d : '0;
        s1_axis_tlast  = (src_q1.size() > 0) ? src_q1[0].l : 1'b0;
        mul_in_tready  = ($urandom_range(99) < in_pct);
        mul_out_tvalid = 1'b0;
        mul_out_tdata  = '0;
        mul_out_tlast  = 1'b0;
        if (mq.size() > 0) begin
            mul_out_tvalid = !mul_stall && (cyc - mq[0].t >= 3) && ($urandom_range(99) < stub_pct);
            mul_out_tdata  = mq[0].b.d ^ XMASK;
            mul_out_tlast  = mq[0].b.l;
        end
        m0_axis_tready = !m0_hold && ($urandom_range(99) < out_pct);
        m1_axis_tready = ($urandom_range(99) < out_pct);
    endtask

    task automatic sample();
        bit h0, h1, hi, ho, hm0, hm1, own;
        beat_t sb;
        logic el;
        h0  = s0_axis_tvalid && s0_axis_tready;
        h1  = s1_axis_tvalid && s1_axis_tready;
        hi  = mul_in_tvalid && mul_in_tready;
        ho  = mul_out_tvalid && mul_out_tready;
        hm0 = m0_axis_tvalid && m0_axis_tready;
        hm1 = m1_axis_tvalid && m1_axis_tready;
        cyc++;
        if (areset) begin
            exp0.delete(); exp1.delete(); mq.delete(); order_q.delete();
            mid_frame = 1'b0; fc_cnt = 0;
            return;
        end
        // forward path: exactly one source handshake per multiplier beat
        if (h0 || h1 || hi) begin
            sb = h1 ? src_q1[0] : src_q0[0];
            el = sb.l;
`ifdef FRAME_CHECK_EN
            fc_cnt++;
            if (fc_cnt == FB) el = 1'b1;
            if (el) fc_cnt = 0;
`endif
            chk(hi && (h0 != h1) && mul_in_tdata == sb.d && mul_in_tlast == el,
                "fwd_beat", {mul_in_tdata[62:0], mul_in_tlast}, {sb.d[62:0], el});
            if (h0) begin exp0.push_back('{d: sb.d ^ XMASK, l: el}); void'(src_q0.pop_front()); sent0++; end
            if (h1) begin exp1.push_back('{d: sb.d ^ XMASK, l: el}); void'(src_q1.pop_front()); sent1++; end
        end
        if (hi) begin
            mq.push_back('{b: '{d: mul_in_tdata, l: mul_in_tlast}, t: cyc});
            if (!mid_frame) order_q.push_back(h1);
            mid_frame = !mul_in_tlast;
        end
        // return path steering against the frame order seen at the multiplier
        if (mul_out_tvalid && order_q.size() > 0) begin
            own = order_q[0];
            chk(own ? (m1_axis_tvalid && !m0_axis_tvalid && mul_out_tready == m1_axis_tready)
                    : (m0_axis_tvalid && !m1_axis_tvalid && mul_out_tready == m0_axis_tready),
                "steer", {m0_axis_tvalid, m1_axis_tvalid, mul_out_tready}, {!own, own, own ? m1_axis_tready : m0_axis_tready});
        end else begin
            chk(!m0_axis_tvalid && !m1_axis_tvalid, "idle_out_valid", {m0_axis_tvalid, m1_axis_tvalid}, 64'h0);
        end
        if (m1_axis_tvalid) m1_seen = 1'b1;
        if (ho) begin
            void'(mq.pop_front());
            if (mul_out_tlast && order_q.size() > 0) void'(order_q.pop_front());
        end
        if (hm0) begin
            chk(exp0.size() > 0, "m0_expected", m0_axis_tdata, 64'h0);
            if (exp0.size() > 0) begin
                chk(m0_axis_tdata == exp0[0].d && m0_axis_tlast == exp0[0].l, "m0_beat",
                    {m0_axis_tdata[62:0], m0_axis_tlast}, {exp0[0].d[62:0], exp0[0].l});
                void'(exp0.pop_front());
            end
            got0++;
            if (m0_axis_tlast) begin outlog.push_back(1'b0); m0_last_seen = 1'b1; end
        end
        if (hm1) begin
            chk(exp1.size() > 0, "m1_expected", m1_axis_tdata, 64'h0);
            if (exp1.size() > 0) begin
                chk(m1_axis_tdata == exp1[0].d && m1_axis_tlast == exp1[0].l, "m1_beat",
                    {m1_axis_tdata[62:0], m1_axis_tlast}, {exp1[0].d[62:0], exp1[0].l});
                void'(exp1.pop_front());
            end
            got1++;
            if (m1_axis_tlast) outlog.push_back(1'b1);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        drive();
        #4;
        sample();
    endtask

    task automatic push_frame(input bit who, input int len, input logic [63:0] base, input bit rnd, input bit with_last);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = rnd ? {$urandom, $urandom} : base;
            b.l = with_last && (i == len - 1);
            if (who) src_q1.push_back(b);
            else src_q0.push_back(b);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q0.size() > 0 || src_q1.size() > 0 || mq.size() > 0 || exp0.size() > 0 ||
                exp1.size() > 0 || dbg_inflight != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(n < budget, "drain_timeout", n, budget);
    endtask

    task automatic do_reset();
        src_q0.delete(); src_q1.delete();
        rst_req = 1'b1; tick(); tick(); rst_req = 1'b0;
    endtask

    gvec_t gv[8];

    initial begin
        int n, g;
        // grant table: {s0 valid, s1 valid, expected first owner}; rr carries over
        gv[0] = '{1'b1, 1'b1, 1'b0}; gv[1] = '{1'b0, 1'b1, 1'b1};
        gv[2] = '{1'b1, 1'b0, 1'b0}; gv[3] = '{1'b1, 1'b1, 1'b1};
        gv[4] = '{1'b1, 1'b1, 1'b1}; gv[5] = '{1'b1, 1'b0, 1'b0};
        gv[6] = '{1'b0, 1'b1, 1'b1}; gv[7] = '{1'b1, 1'b1, 1'b0};

        // reset state
        do_reset();
        tick();
        chk(!mul_in_tvalid && !s0_axis_tready && !s1_axis_tready, "rst_fwd",
            {mul_in_tvalid, s0_axis_tready, s1_axis_tready}, 64'h0);
        chk(!mul_out_tready && !m0_axis_tvalid && !m1_axis_tvalid, "rst_ret",
            {mul_out_tready, m0_axis_tvalid, m1_axis_tvalid}, 64'h0);
        chk(dbg_grant == 2'b00, "rst_grant", dbg_grant, 64'h0);
        chk(dbg_inflight == 0, "rst_inflight", dbg_inflight, 64'h0);
        chk(frame_err == 1'b0, "rst_frame_err", frame_err, 64'h0);

        // table-driven grant decisions with single-beat frames
        for (int i = 0; i < 8; i++) begin
            if (gv[i].v0) push_frame(1'b0, 1, 64'h0, 1'b1, 1'b1);
            if (gv[i].v1) push_frame(1'b1, 1, 64'h0, 1'b1, 1'b1);
            tick();
            tick();
            chk(dbg_grant == {1'b1, gv[i].owner}, "grant_vec", dbg_grant, {62'b0, 1'b1, gv[i].owner});
            chk({s0_axis_tready, s1_axis_tready} == {!gv[i].owner, gv[i].owner}, "tready_vec",
                {s0_axis_tready, s1_axis_tready}, {62'b0, !gv[i].owner, gv[i].owner});
            drain(200);
        end

        // single requester, 16-beat constant frame
        m1_seen = 1'b0; g = got0;
        push_frame(1'b0, 16, 64'h3F80_0000_3F80_0000, 1'b0, 1'b1);
        drain(300);
        chk(!m1_seen, "single_m1_quiet", m1_seen, 64'h0);
        chk(got0 - g == 16, "single_beats", got0 - g, 16);
        chk(dbg_inflight == 0, "single_inflight", dbg_inflight, 64'h0);

        // contention right after reset: s0 first, then s1
        do_reset();
        outlog.delete();
        push_frame(1'b0, 4, 64'h0, 1'b1, 1'b1);
        push_frame(1'b1, 4, 64'h0, 1'b1, 1'b1);
        tick(); tick();
        chk(dbg_grant == 2'b10, "cont_grant", dbg_grant, 64'h2);
        drain(300);
        chk(outlog.size() == 2 && outlog[0] == 1'b0 && outlog[1] == 1'b1, "cont_order",
            {outlog.size(), outlog.size() > 1 ? {outlog[0], outlog[1]} : 2'b11}, 64'h2_01);

        // back-pressure: 50% multiplier input ready, m0 held low mid-return
        in_pct = 50; g = got0; n = 0;
        for (int i = 0; i < 3; i++) push_frame(1'b0, 12, 64'h0, 1'b1, 1'b1);
        while (got0 - g < 5 && n < 500) begin tick(); n++; end
        chk(n < 500, "bp_start_timeout", n, 500);
        m0_hold = 1'b1; g = got0;
        repeat (20) tick();
        chk(got0 == g, "bp_hold", got0, g);
        m0_hold = 1'b0;
        drain(1000);
        in_pct = 100;

        // randomized traffic on both requesters
        s_pct = 70; in_pct = 60; out_pct = 60; stub_pct = 70;
        sent0 = 0; sent1 = 0; got0 = 0; got1 = 0;
        for (int i = 0; i < 20; i++) push_frame(1'($urandom_range(1)), int'($urandom_range(20, 1)), 64'h0, 1'b1, 1'b1);
        drain(8000);
        chk(got0 == sent0 && got1 == sent1, "rand_counts", {got0[15:0], got1[15:0]}, {sent0[15:0], sent1[15:0]});
        s_pct = 100; in_pct = 100; out_pct = 100; stub_pct = 100;

        // FIFO full with the multiplier output stalled
        do_reset();
        mul_stall = 1'b1;
        push_frame(1'b0, 2, 64'h0, 1'b1, 1'b1);
        push_frame(1'b1, 2, 64'h0, 1'b1, 1'b1);
        push_frame(1'b0, 2, 64'h0, 1'b1, 1'b1);
        n = 0;
        while ((src_q1.size() > 0 || src_q0.size() > 2) && n < 50) begin tick(); n++; end
        chk(n < 50, "full_fill_timeout", n, 50);
        repeat (8) begin
            tick();
            chk(!s0_axis_tready && !s1_axis_tready && dbg_inflight == 2, "full_hold",
                {s0_axis_tready, s1_axis_tready, dbg_inflight}, 64'h2);
        end
        mul_stall = 1'b0; m0_last_seen = 1'b0; n = 0;
        while (!m0_last_seen && n < 50) begin tick(); n++; end
        chk(n < 50, "full_pop_timeout", n, 50);
        chk(!s0_axis_tready, "full_at_pop", s0_axis_tready, 64'h0);
        tick();
        chk(dbg_inflight == 1 && dbg_grant == 2'b00, "full_idle", {dbg_inflight, dbg_grant}, 64'h4);
        tick();
        chk(dbg_grant == 2'b10 && s0_axis_tready, "full_regrant", {dbg_grant, s0_axis_tready}, 64'h5);
        drain(300);

        // reset on beat 7 of an s1 frame, then a clean s0 frame
        do_reset();
        sent1 = 0; n = 0;
        push_frame(1'b1, 16, 64'h0, 1'b1, 1'b1);
        while (sent1 < 6 && n < 50) begin tick(); n++; end
        chk(n < 50, "mid_rst_timeout", n, 50);
        rst_req = 1'b1; tick(); rst_req = 1'b0;
        src_q1.delete();
        tick();
        chk(!mul_in_tvalid && !s0_axis_tready && !s1_axis_tready && !mul_out_tready &&
            !m0_axis_tvalid && !m1_axis_tvalid, "mid_rst_quiet",
            {mul_in_tvalid, s0_axis_tready, s1_axis_tready, mul_out_tready, m0_axis_tvalid, m1_axis_tvalid}, 64'h0);
        chk(dbg_inflight == 0 && dbg_grant == 2'b00, "mid_rst_dbg", {dbg_inflight, dbg_grant}, 64'h0);
        g = got0;
        push_frame(1'b0, 8, 64'h0, 1'b1, 1'b1);
        drain(300);
        chk(got0 - g == 8, "post_rst_beats", got0 - g, 8);

`ifdef FRAME_CHECK_EN
        // short frame flags an error; long frame is cut at FRAME_BEATS
        do_reset();
        tick();
        chk(frame_err == 1'b0, "fc_clear", frame_err, 64'h0);
        push_frame(1'b0, 10, 64'h0, 1'b1, 1'b1);
        drain(300);
        chk(frame_err == 1'b1, "fc_short", frame_err, 64'h1);
        g = got0;
        push_frame(1'b0, 20, 64'h0, 1'b1, 1'b1);
        drain(400);
        chk(frame_err == 1'b1 && got0 - g == 20, "fc_long", {frame_err, got0 - g}, 64'h1_14);
`else
        chk(frame_err == 1'b0, "frame_err_tied", frame_err, 64'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fft_mul_arbiter.md
# fft_mul_arbiter

Frame-granular two-requester arbiter that shares the single frequency-domain complex multiplier between two AXI-Stream sources. It grants whole frames (tlast-delimited, nominally 128x128 = 16384 beats of {real[63:32], imag[31:0]} fp32) round-robin. It records each granted frame's owner in a tag FIFO and steers the multiplier's in-order output stream back to the owning requester. It sits between the two upstream FFT streams and the multiplier, and between the multiplier and the inverse-FFT consumers.

## Interface
- DATA_W, 64, beat width (complex fp32 pair)
- TAG_DEPTH, 4, max frames granted but not yet fully returned (power of 2, >=2)
- FRAME_BEATS, 16384, expected beats per frame (used only with FRAME_CHECK_EN)

- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- s0_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DATA_W/1  requester 0 input stream
- s1_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DATA_W/1  requester 1 input stream
- mul_in_tvalid/tready/tdata/tlast  out/in/out/out  1/1/DATA_W/1  to multiplier s_axis
- mul_out_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DATA_W/1  from multiplier m_axis
- m0_axis_tvalid/tready/tdata/tlast  out/in/out/out  1/1/DATA_W/1  results for requester 0
- m1_axis_tvalid/tready/tdata/tlast  out/in/out/out  1/1/DATA_W/1  results for requester 1
- dbg_grant  out  2  {busy, owner}
- dbg_inflight  out  $clog2(TAG_DEPTH)+1  tag FIFO occupancy
- frame_err  out  1  sticky frame-length error (0 when FRAME_CHECK_EN absent)

## Operation
- States: IDLE, BUSY0, BUSY1. Round-robin pointer rr (reset 0 = requester 0 preferred).
- IDLE -> BUSYx when sx_axis_tvalid and tag FIFO not full. If both valid, pick x = rr. On transition: push x into tag FIFO, set rr = ~x.
- BUSYx: combinational pass-through. mul_in_tvalid = sx_tvalid, sx_tready = mul_in_tready, tdata/tlast forwarded. The non-granted s*_tready = 0.
- BUSYx -> IDLE on handshake (valid & ready) with tlast.
- Return path: when tag FIFO non-empty, head tag h selects output. mh_axis_tvalid = mul_out_tvalid, mul_out_tready = mh_axis_tready, the other m*_tvalid = 0. Pop the FIFO on an output handshake with mul_out_tlast.
- FIFO empty: mul_out_tready = 0, both m*_tvalid = 0.
- Simultaneous push and pop in one cycle: occupancy unchanged, both operations take effect.
- Multiplier ordering and tlast are assumed preserved 1:1 (the multiplier is in-order by construction).

## Timing
- Grant latency: 1 cycle from sx_tvalid high in IDLE to the first forwarded beat (BUSYx registered).
- One IDLE bubble after every frame's tlast beat. No back-to-back grant in the same cycle.
- Forward and return paths add 0 cycles of latency (combinational muxes, registered selects).
- Valid must never depend on ready. Upstream tvalid may drop mid-frame; the grant holds until tlast.
- Reset values: state IDLE, rr 0, FIFO empty, all *_tvalid 0, all *_tready 0, dbg_grant 0, dbg_inflight 0, frame_err 0.
- Reset mid-frame: in-flight frames and tags are dropped. The multiplier is reset on the same areset cycle; there is no partial-frame recovery.
- FIFO full (TAG_DEPTH frames outstanding): IDLE holds and both s*_tready stay 0 until a pop.

## Configuration
- FRAME_CHECK_EN defined:
  - A 15-bit beat counter (sized by FRAME_BEATS) runs per granted frame.
  - tlast on beat != FRAME_BEATS sets frame_err.
  - If beat FRAME_BEATS is reached without tlast, frame_err is set and mul_in_tlast is forced high on that beat. The grant ends there; residual upstream beats belong to the next grant.
  - frame_err clears only on areset.
- FRAME_CHECK_EN undefined: no counter, frame_err tied 0, tlast forwarded unmodified.

## Test plan
- Single requester: s0 sends a 16-beat frame (FRAME_BEATS=16) of 0x3F8000003F800000, multiplier stubbed as 3-cycle delay -> 16 beats on m0 with tlast on beat 16, m1_tvalid never high, dbg_inflight returns to 0.
- Contention: s0 and s1 valid in the same IDLE cycle after reset -> s0 granted first, s1 next (rr). Outputs arrive on m0 then m1, in order.
- Back-pressure: toggle mul_in_tready 50% and hold m0_tready low 20 cycles mid-return -> no beat lost or duplicated, data order identical, mul_out_tready follows m0_tready.
- FIFO full: TAG_DEPTH=2, multiplier output stalled -> third frame not granted (s*_tready 0) until the first output tlast handshake, then grant in the following IDLE cycle.
- Reset mid-frame: areset on beat 7 of a s1 frame -> next cycle all valids/readies 0, dbg_inflight 0. A new s0 frame afterward completes correctly.
- FRAME_CHECK_EN: s0 frame with tlast on beat 10 (FRAME_BEATS=16) -> frame_err=1. A frame of 20 beats without tlast -> mul_in_tlast on beat 16, frame_err stays 1.
